// File: rtl/pipe_regmux_nx1.sv
// pipe_regmux_nx1: N-input, WIDTH-bit selector feeding a pipeline register.
// Supports stall/flush, flags out-of-range selects and keeps a saturating error count.
module pipe_regmux_nx1 #(
   parameter int               WIDTH     = 5,
   parameter int               NUM_IN    = 4,
   parameter int               SEL_W     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               ERR_W     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    in_valid,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   output logic [WIDTH-1:0]        out,
   output logic                    out_valid,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err,
   output logic [ERR_W-1:0]        err_cnt
);

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [WIDTH-1:0] out_d,       out_q;
   logic             out_valid_d, out_valid_q;
   logic [SEL_W-1:0] out_sel_d,   out_sel_q;
   logic             sel_err_d,   sel_err_q;
   logic [ERR_W-1:0] err_cnt_d,   err_cnt_q;

   logic [WIDTH-1:0] sel_data_s;
   logic             sel_ok_s;

   // Compare-per-input decode: never slices past the bus, and range check falls out for free.
   always_comb begin
      sel_data_s = RESET_VAL;
      sel_ok_s   = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         sel_data_s = (sel == SEL_W'(k)) ? in_bus[k*WIDTH +: WIDTH] : sel_data_s;
         sel_ok_s   = sel_ok_s | (sel == SEL_W'(k));
      end
   end

   // Next-state: flush > stall > load; reset is applied in the register process.
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      sel_err_d   = sel_err_q;
      err_cnt_d   = err_cnt_q;
      if (flush) begin
         out_d       = RESET_VAL;
         out_valid_d = 1'b0;
         out_sel_d   = {SEL_W{1'b0}};
         sel_err_d   = 1'b0;
      end else if (stall) begin
         out_d       = out_q;
      end else if (in_valid) begin
         out_sel_d = sel;
         if (sel_ok_s) begin
            out_d       = sel_data_s;
            out_valid_d = 1'b1;
            sel_err_d   = 1'b0;
         end else begin
            out_d       = RESET_VAL;
            out_valid_d = 1'b0;
            sel_err_d   = 1'b1;
            err_cnt_d   = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
         end
      end else begin
         out_valid_d = 1'b0;
         sel_err_d   = 1'b0;
      end
   end

   // Pipeline register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= RESET_VAL;
         out_valid_q <= 1'b0;
         out_sel_q   <= {SEL_W{1'b0}};
         sel_err_q   <= 1'b0;
         err_cnt_q   <= {ERR_W{1'b0}};
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
         sel_err_q   <= sel_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;
   assign sel_err   = sel_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pipe_regmux_nx1.sv
// Scoreboard bench for pipe_regmux_nx1: one instance per NUM_IN in 2..16, shared stimulus,
// per-instance reference model pushes expectations that a negedge monitor pops and checks.
module tb_pipe_regmux_nx1;

   typedef struct {
      int out;
      int vld;
      int sel;
      int err;
      int cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid;
   logic [3:0]  sel_full;
   logic [79:0] bus;
   int          lane [16];
   int          tests = 0;
   int          fails = 0;
   logic        done_r = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      bus = 80'd0;
      for (int k = 0; k < 16; k++) bus[k*5 +: 5] = 5'(lane[k]);
   end

   for (genvar n = 2; n <= 16; n++) begin : g_n
      localparam int         SW = $clog2(n);
      localparam logic [4:0] RV = (n % 2 == 0) ? 5'd0 : 5'(n);

      logic [4:0]    out_w;
      logic          vld_w;
      logic [SW-1:0] osel_w;
      logic          err_w;
      logic [1:0]    cnt_w;
      exp_t          q [$];
      int            m_out, m_vld, m_sel, m_err, m_cnt;

      pipe_regmux_nx1 #(.WIDTH(5), .NUM_IN(n), .SEL_W(SW), .RESET_VAL(RV), .ERR_W(2)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .stall    (stall),
         .flush    (flush),
         .in_valid (in_valid),
         .sel      (sel_full[SW-1:0]),
         .in_bus   (bus[n*5-1:0]),
         .out      (out_w),
         .out_valid(vld_w),
         .out_sel  (osel_w),
         .sel_err  (err_w),
         .err_cnt  (cnt_w)
      );

      // Reference model: applies the priority rules to what the inputs were at this edge.
      always @(posedge clk) begin
         int   idx;
         exp_t e;
         idx = int'(sel_full) % (1 << SW);
         if (reset) begin
            m_out = int'(RV); m_vld = 0; m_sel = 0; m_err = 0; m_cnt = 0;
         end else if (flush) begin
            m_out = int'(RV); m_vld = 0; m_sel = 0; m_err = 0;
         end else if (!stall) begin
            if (in_valid) begin
               m_sel = idx;
               if (idx < n) begin
                  m_out = lane[idx]; m_vld = 1; m_err = 0;
               end else begin
                  m_out = int'(RV); m_vld = 0; m_err = 1;
                  m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
               end
            end else begin
               m_vld = 0; m_err = 0;
            end
         end
         e = '{m_out, m_vld, m_sel, m_err, m_cnt};
         q.push_back(e);
      end

      // Monitor: compares the registered outputs against the oldest expectation.
      always @(negedge clk) begin
         exp_t e;
         if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if (int'(out_w) !== e.out || int'(vld_w) !== e.vld || int'(osel_w) !== e.sel ||
                int'(err_w) !== e.err || int'(cnt_w) !== e.cnt) begin
               fails++;
               $display("FAIL regs n=%0d t=%0t got out=%0d vld=%0d sel=%0d err=%0d cnt=%0d required out=%0d vld=%0d sel=%0d err=%0d cnt=%0d",
                        n, $time, out_w, vld_w, osel_w, err_w, cnt_w, e.out, e.vld, e.sel, e.err, e.cnt);
            end
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic f, input logic v, input int sl);
      @(negedge clk);
      reset    = r;
      stall    = s;
      flush    = f;
      in_valid = v;
      sel_full = 4'(sl);
   endtask

   // Watchdog: the stimulus must complete within a bounded number of cycles.
   initial begin
      repeat (50000) @(posedge clk);
      tests++;
      if (done_r !== 1'b1) begin
         fails++;
         $display("FAIL timeout t=%0t stimulus did not complete within 50000 cycles", $time);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; sel_full = 4'd0;
      for (int k = 0; k < 16; k++) lane[k] = int'($urandom_range(31, 0));
      lane[0] = 3; lane[1] = 10; lane[2] = 20; lane[3] = 31;

      step(1'b1, 1'b0, 1'b0, 1'b1, 2);
      step(1'b1, 1'b0, 1'b0, 1'b1, 2);
      tests++;
      if (g_n[4].out_w !== 5'd0 || g_n[4].vld_w !== 1'b0 || g_n[4].osel_w !== 2'd0 ||
          g_n[4].err_w !== 1'b0 || g_n[4].cnt_w !== 2'd0) begin
         fails++;
         $display("FAIL reset t=%0t got out=%0d vld=%0d sel=%0d err=%0d cnt=%0d required out=0 vld=0 sel=0 err=0 cnt=0",
                  $time, g_n[4].out_w, g_n[4].vld_w, g_n[4].osel_w, g_n[4].err_w, g_n[4].cnt_w);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 2);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1);
      // Saturation run with a stall in the middle, then a reset clears the count.
      step(1'b0, 1'b0, 1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3);
      step(1'b0, 1'b1, 1'b0, 1'b1, 3);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 3);
      step(1'b1, 1'b0, 1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(63, 0) == 0), ($urandom_range(4, 0) == 0),
              ($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0),
              int'($urandom_range(15, 0)));
         for (int k = 0; k < 16; k++) lane[k] = int'($urandom_range(31, 0));
      end

      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      done_r = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
